// File: rtl/uart_pkg.sv
// uart_pkg: register map, bit indices, parity encodings and FSM states shared by the UART block.
package uart_pkg;
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_BAUD   = 8'h08;
  localparam logic [7:0] REG_TXDATA = 8'h0C;
  localparam logic [7:0] REG_RXDATA = 8'h10;
  localparam logic [7:0] REG_LEVEL  = 8'h14;
  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_RX_EN  = 1;
  localparam int CTRL_STOP2  = 2;
  localparam int CTRL_PAR_LO = 4;
  localparam int ST_TX_FULL  = 0;
  localparam int ST_RX_AVAIL = 1;
  localparam int ST_TX_BUSY  = 2;
  localparam int ST_OVERRUN  = 3;
  localparam int ST_FRAME    = 4;
  localparam int ST_PARITY   = 5;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
endpackage

// File: rtl/uart_fifo_ctrl_if.sv
// uart_fifo_ctrl_if: peripheral bus with req/we/addr/data and single-cycle ack.
interface uart_fifo_ctrl_if;
  logic req_i, we_i, ack_o;
  logic [31:0] addr_i, data_i, data_o;
  modport master (output req_i, we_i, addr_i, data_i, input data_o, ack_o);
  modport slave (input req_i, we_i, addr_i, data_i, output data_o, ack_o);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CAP = CW'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CAP;
  assign do_pop = pop & ~empty;
  // a full FIFO still accepts a push when the same edge pops
  assign do_push = push & (~full | do_pop);
  assign rdata = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: bus-mapped UART with TX/RX FIFOs, 1/2 stop bits and sticky error flags.
// Parity generation/checking is built only when UART_PARITY_EN is defined.
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int FIFO_DEPTH = 8,
  parameter logic [31:0] BAUD_RST = 32'h1B8
) (
  input  logic clk,
  input  logic rst,
  uart_fifo_ctrl_if.slave bus,
  output logic tx_pin,
  input  logic rx_pin
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] LAST = 3'(DATA_BITS - 1);
  logic tx_en, rx_en, stop2, ovr, frm, par_err, par_on, par_odd;
  logic [1:0] par_mode;
  logic [31:0] baud;
  logic [7:0] a;
  logic wr, w1c, tx_push, rx_pop, rx_push, rx_ovr_set, rx_frm_set;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_busy, tx_go;
  logic [CW-1:0] tx_lvl, rx_lvl;
  logic [DATA_BITS-1:0] tx_head, rx_head, tx_sh, tx_sh_d, rx_sh, rx_sh_d;
  state_t tx_st, tx_st_d, rx_st, rx_st_d;
  logic [15:0] tx_tmr, tx_tmr_d, rx_tmr, rx_tmr_d;
  logic [2:0] tx_idx, tx_idx_d, rx_idx, rx_idx_d;
  logic tx_stp, tx_stp_d, tx_pin_d, tx_pop, rx_s1, rx_s2, rx_q;
  assign a = bus.addr_i[7:0];
  assign wr = bus.req_i & bus.we_i;
  assign w1c = wr && a == REG_STATUS;
  assign tx_push = wr && a == REG_TXDATA;
  assign rx_pop = bus.req_i && !bus.we_i && a == REG_RXDATA && !rx_empty;
  assign bus.ack_o = bus.req_i;
  assign par_on = par_mode == PAR_EVEN || par_mode == PAR_ODD;
  assign par_odd = par_mode == PAR_ODD;
  assign tx_go = tx_en & ~tx_empty;
  assign tx_busy = ~tx_empty | (tx_st != S_IDLE);
  assign rx_ovr_set = rx_push & rx_full & ~rx_pop;
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(bus.data_i[DATA_BITS-1:0]),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_lvl)
  );
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(rx_sh),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_lvl)
  );
  always_comb begin
    bus.data_o = '0;
    if (rst)
      case (a)
        REG_CTRL:   bus.data_o = {26'b0, par_mode, 1'b0, stop2, rx_en, tx_en};
        REG_STATUS: bus.data_o = {26'b0, par_err, frm, ovr, tx_busy, ~rx_empty, tx_full};
        REG_BAUD:   bus.data_o = baud;
        REG_RXDATA: bus.data_o = rx_empty ? '0 : 32'(rx_head);
        REG_LEVEL:  bus.data_o = {16'b0, 8'(rx_lvl), 8'(tx_lvl)};
        default:    bus.data_o = '0;
      endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      {stop2, rx_en, tx_en} <= '0;
      baud <= BAUD_RST;
      ovr <= 1'b0;
      frm <= 1'b0;
    end else begin
      if (wr && a == REG_CTRL) {stop2, rx_en, tx_en} <= bus.data_i[CTRL_STOP2:CTRL_TX_EN];
      if (wr && a == REG_BAUD) baud <= bus.data_i;
      ovr <= rx_ovr_set | (ovr & ~(w1c & bus.data_i[ST_OVERRUN]));
      frm <= rx_frm_set | (frm & ~(w1c & bus.data_i[ST_FRAME]));
    end
  end
`ifdef UART_PARITY_EN
  logic rx_par_set;
  always_ff @(posedge clk) begin
    if (!rst) begin
      par_mode <= PAR_NONE;
      par_err <= 1'b0;
    end else begin
      if (wr && a == REG_CTRL) par_mode <= bus.data_i[CTRL_PAR_LO+1:CTRL_PAR_LO];
      par_err <= rx_par_set | (par_err & ~(w1c & bus.data_i[ST_PARITY]));
    end
  end
`else
  assign par_mode = PAR_NONE;
  assign par_err = 1'b0;
`endif
  // the shifter rotates, so after the data bits it holds the word again for parity
  always_comb begin
    tx_st_d = tx_st;
    tx_tmr_d = (tx_st == S_IDLE || tx_tmr == '0) ? baud[15:0] : tx_tmr - 16'd1;
    tx_sh_d = tx_sh;
    tx_idx_d = tx_idx;
    tx_stp_d = tx_stp;
    tx_pop = 1'b0;
    if (tx_tmr == '0)
      case (tx_st)
        S_START: tx_st_d = S_DATA;
        S_DATA: begin
          tx_sh_d = {tx_sh[0], tx_sh[DATA_BITS-1:1]};
          tx_idx_d = tx_idx + 3'd1;
          if (tx_idx == LAST) tx_st_d = par_on ? S_PARITY : S_STOP;
        end
        S_PARITY: tx_st_d = S_STOP;
        S_STOP: begin
          tx_stp_d = 1'b0;
          if (!tx_stp) tx_st_d = S_IDLE;
        end
        default: tx_st_d = tx_st;
      endcase
    if (tx_st_d == S_IDLE && tx_go) begin
      tx_st_d = S_START;
      tx_pop = 1'b1;
      tx_sh_d = tx_head;
      tx_idx_d = '0;
      tx_stp_d = stop2;
    end
    tx_pin_d = tx_st_d == S_START ? 1'b0 : tx_st_d == S_DATA ? tx_sh_d[0] :
               tx_st_d == S_PARITY ? (^tx_sh_d) ^ par_odd : 1'b1;
  end
  always_comb begin
    rx_st_d = rx_st;
    rx_tmr_d = rx_tmr - 16'd1;
    rx_sh_d = rx_sh;
    rx_idx_d = rx_idx;
    rx_push = 1'b0;
    rx_frm_set = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_set = 1'b0;
`endif
    if (!rx_en) rx_st_d = S_IDLE;
    else if (rx_st == S_IDLE) begin
      rx_tmr_d = {1'b0, baud[15:1]};
      if (rx_q && !rx_s2) rx_st_d = S_START;
    end else if (rx_tmr == '0) begin
      rx_tmr_d = baud[15:0];
      case (rx_st)
        S_START: begin
          rx_st_d = rx_s2 ? S_IDLE : S_DATA;
          rx_idx_d = '0;
        end
        S_DATA: begin
          rx_sh_d = {rx_s2, rx_sh[DATA_BITS-1:1]};
          rx_idx_d = rx_idx + 3'd1;
          if (rx_idx == LAST) rx_st_d = par_on ? S_PARITY : S_STOP;
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          rx_par_set = rx_s2 ^ (^rx_sh) ^ par_odd;
          rx_st_d = S_STOP;
        end
`endif
        S_STOP: begin
          rx_push = rx_s2;
          rx_frm_set = ~rx_s2;
          rx_st_d = S_IDLE;
        end
        default: rx_st_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_st <= S_IDLE;
      tx_tmr <= '0;
      tx_sh <= '0;
      tx_idx <= '0;
      tx_stp <= 1'b0;
      tx_pin <= 1'b1;
      rx_st <= S_IDLE;
      rx_tmr <= '0;
      rx_sh <= '0;
      rx_idx <= '0;
      {rx_s1, rx_s2, rx_q} <= 3'b111;
    end else begin
      tx_st <= tx_st_d;
      tx_tmr <= tx_tmr_d;
      tx_sh <= tx_sh_d;
      tx_idx <= tx_idx_d;
      tx_stp <= tx_stp_d;
      tx_pin <= tx_pin_d;
      rx_st <= rx_st_d;
      rx_tmr <= rx_tmr_d;
      rx_sh <= rx_sh_d;
      rx_idx <= rx_idx_d;
      {rx_s1, rx_s2, rx_q} <= {rx_pin, rx_s1, rx_s2};
    end
  end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: directed bench for uart_fifo_ctrl (BAUD=3, 4 clocks per bit).
module tb_uart_fifo_ctrl;
  logic clk, rst, tx_pin, rx_pin, rx_drv, loop;
  logic [31:0] rdata;
  logic [15:0] bits;
  bit ok;
  int checks = 0, failures = 0;
  uart_fifo_ctrl_if bus();
  uart_fifo_ctrl dut (.clk(clk), .rst(rst), .bus(bus), .tx_pin(tx_pin), .rx_pin(rx_pin));
  assign rx_pin = loop ? tx_pin : rx_drv;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    bus.req_i = 1'b1;
    bus.we_i = 1'b1;
    bus.addr_i = {24'b0, a};
    bus.data_i = d;
    cyc(1);
    bus.req_i = 1'b0;
    bus.we_i = 1'b0;
  endtask
  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    bus.req_i = 1'b1;
    bus.we_i = 1'b0;
    bus.addr_i = {24'b0, a};
    #1 d = bus.data_o;
    cyc(1);
    bus.req_i = 1'b0;
  endtask
  task automatic wait_fall(output bit found);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      cyc(1);
      if (!tx_pin) found = 1'b1;
    end
  endtask
  task automatic grab(input int lead, input int n, output logic [15:0] b);
    b = '0;
    cyc(lead);
    for (int i = 0; i < n; i++) begin
      b[i] = tx_pin;
      if (i < n - 1) cyc(4);
    end
  endtask
  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      rx_drv = v[i];
      cyc(4);
    end
    rx_drv = 1'b1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b0;
    loop = 1'b0;
    rx_drv = 1'b1;
    bus.req_i = 1'b0;
    bus.we_i = 1'b0;
    bus.addr_i = '0;
    bus.data_i = '0;
    cyc(3);
    bus.addr_i = 32'h8;
    #1 chk("data_o_in_reset", bus.data_o, 32'h0);
    chk("tx_pin_reset", tx_pin, 1'b1);
    rst = 1'b1;
    bus.req_i = 1'b1;
    bus.addr_i = 32'h0;
    #1 chk("ack_eq_req", bus.ack_o, 1'b1);
    chk("ctrl_reset", bus.data_o, 32'h0);
    cyc(1);
    bus.req_i = 1'b0;
    bus_rd(8'h08, rdata); chk("baud_reset", rdata, 32'h1B8);
    bus_rd(8'h04, rdata); chk("status_reset", rdata, 32'h0);
    bus_rd(8'h14, rdata); chk("level_reset", rdata, 32'h0);
    bus_wr(8'h08, 32'd3);
    bus_wr(8'h00, 32'h1);
    bus_wr(8'h0C, 32'h55);
    wait_fall(ok); chk("tx55_start_seen", ok, 1'b1);
    grab(2, 10, bits); chk("tx55_frame", bits, {1'b1, 8'h55, 1'b0});
    bus_rd(8'h04, rdata); chk("busy_in_stop", rdata, 32'h4);
    cyc(2);
    bus_rd(8'h04, rdata); chk("busy_after_stop", rdata, 32'h0);
    chk("tx_idle_high", tx_pin, 1'b1);
    bus_wr(8'h00, 32'h0);
    for (int i = 1; i <= 9; i++) bus_wr(8'h0C, 32'(i));
    bus_rd(8'h14, rdata); chk("level_tx_full", rdata, 32'h8);
    bus_rd(8'h04, rdata); chk("status_tx_full", rdata, 32'h5);
    bus_wr(8'h00, 32'h1);
    wait_fall(ok); chk("fill_start_seen", ok, 1'b1);
    for (int j = 0; j < 8; j++) begin
      grab(j == 0 ? 2 : 4, 10, bits);
      chk($sformatf("fill_frame%0d", j), bits, 16'({1'b1, 8'(j + 1), 1'b0}));
    end
    cyc(4);
    chk("no_ninth_frame", tx_pin, 1'b1);
    bus_rd(8'h14, rdata); chk("level_after_fill", rdata, 32'h0);
    loop = 1'b1;
    bus_wr(8'h00, 32'h3);
    bus_wr(8'h0C, 32'hA3);
    bus_wr(8'h0C, 32'h3C);
    cyc(100);
    bus_rd(8'h04, rdata); chk("loop_rx_avail", rdata, 32'h2);
    bus_rd(8'h14, rdata); chk("loop_level", rdata, 32'h0200);
    bus_rd(8'h10, rdata); chk("loop_rx0", rdata, 32'hA3);
    bus_rd(8'h10, rdata); chk("loop_rx1", rdata, 32'h3C);
    bus_rd(8'h10, rdata); chk("loop_rx_empty", rdata, 32'h0);
    loop = 1'b0;
    rx_drv = 1'b0;
    cyc(1);
    rx_drv = 1'b1;
    cyc(20);
    bus_rd(8'h04, rdata); chk("glitch_status", rdata, 32'h0);
    bus_rd(8'h14, rdata); chk("glitch_level", rdata, 32'h0);
    send_bits({1'b0, 8'h5A, 1'b0}, 10);
    cyc(8);
    bus_rd(8'h04, rdata); chk("frame_err_status", rdata, 32'h10);
    bus_rd(8'h14, rdata); chk("frame_err_level", rdata, 32'h0);
    for (int i = 0; i < 9; i++) begin
      send_bits({1'b1, 8'(8'h30 + i), 1'b0}, 10);
      cyc(4);
    end
    cyc(8);
    bus_rd(8'h04, rdata); chk("overrun_status", rdata, 32'h1A);
    bus_rd(8'h14, rdata); chk("overrun_level", rdata, 32'h0800);
    bus_wr(8'h04, 32'h18);
    bus_rd(8'h04, rdata); chk("w1c_cleared", rdata, 32'h2);
    for (int i = 0; i < 8; i++) begin
      bus_rd(8'h10, rdata);
      chk($sformatf("overrun_word%0d", i), rdata, 32'h30 + 32'(i));
    end
    bus_rd(8'h10, rdata); chk("rx_drained", rdata, 32'h0);
`ifdef UART_PARITY_EN
    bus_wr(8'h00, 32'h13);
    bus_rd(8'h00, rdata); chk("ctrl_parity", rdata, 32'h13);
    bus_wr(8'h0C, 32'h07);
    wait_fall(ok); chk("par_start_seen", ok, 1'b1);
    grab(2, 11, bits); chk("tx_even_parity", bits, {1'b1, 1'b1, 8'h07, 1'b0});
    cyc(4);
    send_bits({1'b1, 1'b0, 8'h07, 1'b0}, 11);
    cyc(8);
    bus_rd(8'h04, rdata); chk("parity_err_status", rdata, 32'h22);
    bus_rd(8'h10, rdata); chk("parity_word_pushed", rdata, 32'h07);
    bus_wr(8'h04, 32'h20);
    bus_rd(8'h04, rdata); chk("parity_err_cleared", rdata, 32'h0);
`else
    bus_wr(8'h00, 32'h33);
    bus_rd(8'h00, rdata); chk("ctrl_parity_ignored", rdata, 32'h3);
`endif
    bus_wr(8'h00, 32'h3);
    bus_wr(8'h0C, 32'h0);
    bus_wr(8'h0C, 32'h0);
    bus_wr(8'h0C, 32'h0);
    wait_fall(ok); chk("rst_frame_seen", ok, 1'b1);
    bus_rd(8'h14, rdata); chk("level_mid_frame", rdata, 32'h2);
    cyc(7);
    chk("tx_data_low", tx_pin, 1'b0);
    rst = 1'b0;
    cyc(1);
    chk("tx_pin_after_rst", tx_pin, 1'b1);
    rst = 1'b1;
    bus_rd(8'h14, rdata); chk("level_after_rst", rdata, 32'h0);
    bus_rd(8'h08, rdata); chk("baud_after_rst", rdata, 32'h1B8);
    bus_rd(8'h00, rdata); chk("ctrl_after_rst", rdata, 32'h0);
    cyc(20);
    chk("tx_stays_idle", tx_pin, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
